// File: rtl/pc_target_table.sv
// pc_target_table: run-time programmable branch-target table with a post-reset clear sweep
// and a 1-cycle lookup/next-PC path. Optional macro PCT_WR_BYPASS_EN forwards same-edge writes to reads.
module pc_target_table #(
  parameter int D = 12,
  parameter int A = 6
) (
  input  logic         Clk,
  input  logic         Reset,
  output logic         init_done,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         wr_abs,
  input  logic         rd_en,
  input  logic [A-1:0] rd_addr,
  input  logic [D-1:0] pc_in,
  input  logic         taken,
  output logic [D-1:0] target,
  output logic         target_abs,
  output logic [D-1:0] next_pc,
  output logic         target_valid
);
  localparam int DEPTH = 2**A;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t       state_q;
  logic [A-1:0] clr_ptr_q;
  logic         init_done_q;
  logic [D-1:0] target_q;
  logic         target_abs_q;
  logic [D-1:0] next_pc_q;
  logic         target_valid_q;

  logic [D-1:0] ent_data [DEPTH];
  logic         ent_abs  [DEPTH];

  logic [D-1:0] rd_data_d;
  logic         rd_abs_d;
  logic [D-1:0] next_pc_d;

  always_comb begin
    rd_data_d = ent_data[rd_addr];
    rd_abs_d  = ent_abs[rd_addr];
`ifdef PCT_WR_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data_d = wr_data;
      rd_abs_d  = wr_abs;
    end
`endif
    next_pc_d = pc_in + D'(1);
    if (taken) begin
      next_pc_d = rd_abs_d ? rd_data_d : (pc_in + rd_data_d);
    end
  end

  // Table storage: the sweep owns the write port while clearing, the user port afterwards.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state_q == CLEAR) begin
        ent_data[clr_ptr_q] <= '0;
        ent_abs[clr_ptr_q]  <= 1'b0;
      end else if (wr_en) begin
        ent_data[wr_addr] <= wr_data;
        ent_abs[wr_addr]  <= wr_abs;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= CLEAR;
      clr_ptr_q      <= '0;
      init_done_q    <= 1'b0;
      target_q       <= '0;
      target_abs_q   <= 1'b0;
      next_pc_q      <= '0;
      target_valid_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          target_valid_q <= 1'b0;
          clr_ptr_q      <= clr_ptr_q + A'(1);
          if (&clr_ptr_q) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          target_valid_q <= rd_en;
          if (rd_en) begin
            target_q     <= rd_data_d;
            target_abs_q <= rd_abs_d;
            next_pc_q    <= next_pc_d;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign init_done    = init_done_q;
  assign target       = target_q;
  assign target_abs   = target_abs_q;
  assign next_pc      = next_pc_q;
  assign target_valid = target_valid_q;

endmodule

// File: doc/pc_target_table.md
Name: pc_target_table

Overview:
Programmable successor to the fixed branch-target lookup table in the fetch stage. Holds 2**A entries of D-bit branch targets plus a per-entry mode bit (relative offset or absolute line). Entries are written at run time instead of being hardcoded. On a lookup, the block returns the entry and the computed next PC one cycle later. After reset, a built-in sweep clears every entry before lookups are accepted.

Parameters:
D, 12, width of PC, target and offset (two's complement for relative entries)
A, 6, index width; table depth DEPTH = 2**A (derived, not overridable)

Ports:
Clk  input  1  single clock, all state updates on rising edge
Reset  input  1  synchronous, active-high
init_done  output  1  high once the clear sweep has finished; lookups and writes accepted only while high
wr_en  input  1  write strobe
wr_addr  input  A  entry index to write
wr_data  input  D  target value (signed offset or absolute line)
wr_abs  input  1  mode for written entry: 1 absolute, 0 PC-relative
rd_en  input  1  lookup strobe
rd_addr  input  A  entry index to look up
pc_in  input  D  current PC, sampled with rd_en
taken  input  1  branch outcome, sampled with rd_en
target  output  D  raw entry data from last lookup
target_abs  output  1  mode bit from last lookup
next_pc  output  D  computed next PC from last lookup
target_valid  output  1  one-cycle pulse marking a completed lookup

Behaviour:
- Reset=1 at an edge: state<=CLEAR, clr_ptr<=0, init_done<=0, target<=0, target_abs<=0, next_pc<=0, target_valid<=0. Reset has priority over every other input.
- A Reset asserted mid-RUN restarts the sweep; all entries are cleared again.
- CLEAR state: each edge with Reset=0 writes entry[clr_ptr] <= {abs=0, data=0} and increments clr_ptr.
  - Edges 1..DEPTH after Reset falls clear entries 0..DEPTH-1.
  - At the edge that clears entry DEPTH-1: state<=RUN, init_done<=1.
  - wr_en and rd_en are ignored throughout CLEAR; target_valid stays 0.
- RUN state, write: wr_en=1 at an edge stores {wr_abs, wr_data} into entry[wr_addr]. Zero latency to the next edge.
- RUN state, lookup: rd_en=1 at edge N loads the following values, visible after edge N (latency 1):
  - target <= entry.data and target_abs <= entry.abs.
  - next_pc <= pc_in+1 if taken=0.
  - next_pc <= pc_in+entry.data (mod 2**D, wrap-around, no saturation) if taken=1 and abs=0.
  - next_pc <= entry.data if taken=1 and abs=1.
  - target_valid <= 1.
- rd_en=0 at an edge: target_valid <= 0. target, target_abs and next_pc hold their values.
- Back-to-back rd_en: one result per cycle, each with target_valid=1.
- Read and write to the same index at the same edge: the lookup returns the old entry contents. The write still takes effect (see Optional Feature for the exception).
- Read and write to different indices at the same edge: independent, no interaction.
- No out-of-range indices exist (DEPTH = 2**A exactly).

Optional Feature:
PCT_WR_BYPASS_EN
- Defined: a same-edge read and write to the same index forwards the new data. target, target_abs and next_pc are computed from wr_data/wr_abs. The entry is still written.
- Undefined: read-before-write behaviour as specified in Behaviour.
- No other difference in either build.

Test Plan:
- Reset for 2 cycles, then release. Expect init_done=0 for 64 edges and rising after edge 64. rd_en pulses during the sweep give target_valid=0. A lookup of entry 63 after the sweep returns target=0, next_pc=pc_in+1 (taken=0).
- Write entry 16 = {abs=0, 14}. Lookup 16 with pc_in=100, taken=1 -> one cycle later target=14, next_pc=114, target_valid=1 for exactly one cycle.
- Write entry 17 = {abs=0, -142 (12'hF72)}. Lookup with pc_in=5, taken=1 -> next_pc=12'hF77 (wrap). Same lookup with taken=0 -> next_pc=6.
- Write entry 3 = {abs=1, 40}. Lookup with pc_in=7, taken=1 -> next_pc=40, target_abs=1.
- Same-edge write {abs=0, 9} and read of entry 5, where entry 5 holds 2, pc_in=10, taken=1:
  - Without PCT_WR_BYPASS_EN: next_pc=12.
  - With PCT_WR_BYPASS_EN: next_pc=19.
  - A follow-up read returns 9 in both builds.
- Program entry 20=7, assert Reset for one edge mid-RUN -> init_done drops, 64-cycle sweep repeats, and a subsequent lookup of entry 20 returns 0.
